// File: rtl/latency_aware_switch.sv
// Registered N_IN x N_OUT crossbar with per-input FIFOs, round-robin input fairness and
// optional latency-aware output selection (enabled by defining SWITCH_LATENCY_AWARE_EN).
module latency_aware_switch #(
   parameter int DWIDTH              = 16,
   parameter int LATENCY_COUNT_WIDTH = 5,
   parameter int N_IN                = 4,
   parameter int N_OUT               = 4,
   parameter int IN_DEPTH            = 2
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic [N_IN-1:0]                     in_valid,
   input  logic [N_IN*DWIDTH-1:0]              in_data,
   output logic [N_IN-1:0]                     in_ready,
   output logic [N_IN*LATENCY_COUNT_WIDTH-1:0] in_latency,
   output logic [N_OUT-1:0]                    out_valid,
   output logic [N_OUT*DWIDTH-1:0]             out_data,
   input  logic [N_OUT-1:0]                    out_ready,
   input  logic [N_OUT*LATENCY_COUNT_WIDTH-1:0] out_latency
);

   localparam int LCW = LATENCY_COUNT_WIDTH;
   localparam int PW  = $clog2(IN_DEPTH);
   localparam int CW  = PW + 1;
   localparam int RW  = $clog2(N_IN);

   logic [DWIDTH-1:0] mem_q    [N_IN][IN_DEPTH];
   logic [PW-1:0]     wr_ptr_q [N_IN];
   logic [PW-1:0]     rd_ptr_q [N_IN];
   logic [CW-1:0]     cnt_q    [N_IN];
   logic [DWIDTH-1:0] head     [N_IN];

   logic [N_IN-1:0]         push;
   logic [N_IN-1:0]         grant;
   logic [N_OUT-1:0]        avail;
   logic [N_OUT-1:0]        taken;
   logic [N_OUT-1:0]        out_load;
   logic [RW-1:0]           out_src [N_OUT];
   logic [RW-1:0]           rr_q, rr_d;
   logic [N_OUT-1:0]        out_valid_q;
   logic [N_OUT*DWIDTH-1:0] out_data_q;

   int   idx;
   int   best;
   logic found;
`ifdef SWITCH_LATENCY_AWARE_EN
   logic [LCW-1:0] best_lat;
`endif

   // Ready depends only on FIFO occupancy and reset, never on downstream ready.
   always_comb begin
      for (int i = 0; i < N_IN; i++) begin
         in_ready[i] = ~rst & (cnt_q[i] != CW'(IN_DEPTH));
         head[i]     = mem_q[i][rd_ptr_q[i]];
      end
   end

   assign push  = in_valid & in_ready;
   assign avail = ~out_valid_q | out_ready;

   // NOTE: every variable written here gets a default first, so no path leaves one unassigned
   // and no latch is inferred.
   always_comb begin
      taken    = '0;
      grant    = '0;
      out_load = '0;
      rr_d     = rr_q;
      idx      = 0;
      best     = 0;
      found    = 1'b0;
`ifdef SWITCH_LATENCY_AWARE_EN
      best_lat = '1;
`endif
      for (int j = 0; j < N_OUT; j++) out_src[j] = '0;
      for (int k = 0; k < N_IN; k++) begin
         idx = int'(rr_q) + k;
         if (idx >= N_IN) idx = idx - N_IN;
         if (cnt_q[idx] != '0) begin
            found = 1'b0;
            best  = 0;
`ifdef SWITCH_LATENCY_AWARE_EN
            best_lat = '1;
`endif
            for (int j = 0; j < N_OUT; j++) begin
               if (avail[j] && !taken[j]) begin
`ifdef SWITCH_LATENCY_AWARE_EN
                  // Strict compare keeps the lowest index on a latency tie.
                  if (!found || (out_latency[j*LCW +: LCW] < best_lat)) begin
                     found    = 1'b1;
                     best     = j;
                     best_lat = out_latency[j*LCW +: LCW];
                  end
`else
                  if (!found) begin
                     found = 1'b1;
                     best  = j;
                  end
`endif
               end
            end
            if (found) begin
               taken[best]    = 1'b1;
               out_load[best] = 1'b1;
               out_src[best]  = idx[RW-1:0];
               grant[idx]     = 1'b1;
               rr_d           = (idx == N_IN - 1) ? '0 : RW'(idx + 1);
            end
         end
      end
   end

   // NOTE: FIFO storage carries no reset; the cleared counts make stale entries unreachable.
   always_ff @(posedge clk) begin
      for (int i = 0; i < N_IN; i++) begin
         if (push[i]) mem_q[i][wr_ptr_q[i]] <= in_data[i*DWIDTH +: DWIDTH];
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         rr_q        <= '0;
         out_valid_q <= '0;
         out_data_q  <= '0;
         for (int i = 0; i < N_IN; i++) begin
            wr_ptr_q[i] <= '0;
            rd_ptr_q[i] <= '0;
            cnt_q[i]    <= '0;
         end
      end else begin
         rr_q <= rr_d;
         for (int i = 0; i < N_IN; i++) begin
            if (push[i])  wr_ptr_q[i] <= wr_ptr_q[i] + 1'b1;
            if (grant[i]) rd_ptr_q[i] <= rd_ptr_q[i] + 1'b1;
            cnt_q[i] <= cnt_q[i] + CW'(push[i]) - CW'(grant[i]);
         end
         for (int j = 0; j < N_OUT; j++) begin
            if (out_load[j]) begin
               out_valid_q[j]                  <= 1'b1;
               out_data_q[j*DWIDTH +: DWIDTH] <= head[out_src[j]];
            end else if (out_ready[j]) begin
               out_valid_q[j] <= 1'b0;
            end
         end
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;

`ifdef SWITCH_LATENCY_AWARE_EN
   localparam logic [LCW:0] SWITCH_LAT = (LCW+1)'(2);

   logic [LCW-1:0] min_lat;
   logic [LCW:0]   lat_sum;
   logic [LCW-1:0] lat_d, lat_q;

   always_comb begin
      min_lat = out_latency[0 +: LCW];
      for (int j = 1; j < N_OUT; j++) begin
         if (out_latency[j*LCW +: LCW] < min_lat) min_lat = out_latency[j*LCW +: LCW];
      end
   end

   assign lat_sum = {1'b0, min_lat} + SWITCH_LAT;
   assign lat_d   = lat_sum[LCW] ? '1 : lat_sum[LCW-1:0];

   always_ff @(posedge clk) begin
      if (rst) lat_q <= '1;
      else     lat_q <= lat_d;
   end

   assign in_latency = {N_IN{lat_q}};
`else
   logic unused_out_latency;
   assign unused_out_latency = ^out_latency;
   assign in_latency         = '0;
`endif

endmodule

// File: tb/tb_latency_aware_switch.sv
// Directed self-checking bench for latency_aware_switch; expectations follow whether
// SWITCH_LATENCY_AWARE_EN is defined for the build.
module tb_latency_aware_switch;

   localparam int DW = 16;
   localparam int LW = 5;
   localparam int NI = 4;
   localparam int NO = 4;

   logic             clk = 1'b0;
   logic             rst;
   logic [NI-1:0]    in_valid;
   logic [NI*DW-1:0] in_data;
   logic [NI-1:0]    in_ready;
   logic [NI*LW-1:0] in_latency;
   logic [NO-1:0]    out_valid;
   logic [NO*DW-1:0] out_data;
   logic [NO-1:0]    out_ready;
   logic [NO*LW-1:0] out_latency;

   int checks = 0;
   int errors = 0;

   latency_aware_switch #(
      .DWIDTH(DW), .LATENCY_COUNT_WIDTH(LW), .N_IN(NI), .N_OUT(NO), .IN_DEPTH(2)
   ) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready), .in_latency(in_latency),
      .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
      .out_latency(out_latency)
   );

   always #5 clk = ~clk;

   function automatic logic [NI*LW-1:0] lat_all(input logic [LW-1:0] v);
`ifdef SWITCH_LATENCY_AWARE_EN
      return {NI{v}};
`else
      return '0;
`endif
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_lat(input logic [LW-1:0] l0, l1, l2, l3);
      out_latency = {l3, l2, l1, l0};
   endtask

   task automatic do_reset();
      rst      = 1'b1;
      in_valid = '0;
      step();
      rst = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = '0; in_data = '0; out_ready = '1;
      set_lat(5'd3, 5'd1, 5'd2, 5'd4);
      #1;
      checks++;
      if (in_ready !== 4'h0) begin errors++; $display("FAIL reset_in_ready_low: got %h expected 0", in_ready); end
      step(); step();
      checks++;
      if (out_valid !== 4'h0) begin errors++; $display("FAIL reset_out_valid: got %h expected 0", out_valid); end
      checks++;
      if (out_data !== '0) begin errors++; $display("FAIL reset_out_data: got %h expected 0", out_data); end
      checks++;
      if (in_latency !== lat_all(5'd31)) begin
         errors++; $display("FAIL reset_in_latency: got %h expected %h", in_latency, lat_all(5'd31));
      end
      rst = 1'b0;
      #1;
      checks++;
      if (in_ready !== 4'hF) begin errors++; $display("FAIL reset_in_ready_high: got %h expected f", in_ready); end
   endtask

   task automatic test_single_beat();
      logic [NO-1:0] exp_v;
      int            exp_j;
`ifdef SWITCH_LATENCY_AWARE_EN
      exp_v = 4'b0010; exp_j = 1;
`else
      exp_v = 4'b0001; exp_j = 0;
`endif
      set_lat(5'd3, 5'd1, 5'd2, 5'd4);
      out_ready = '1;
      do_reset();
      in_valid = 4'b0001; in_data[15:0] = 16'h00FF;
      step();
      in_valid = '0;
      checks++;
      if (out_valid !== 4'h0) begin errors++; $display("FAIL single_too_early: got %h expected 0", out_valid); end
      step();
      checks++;
      if (out_valid !== exp_v) begin errors++; $display("FAIL single_out_valid: got %b expected %b", out_valid, exp_v); end
      checks++;
      if (out_data[exp_j*DW +: DW] !== 16'h00FF) begin
         errors++; $display("FAIL single_out_data: got %h expected 00ff", out_data[exp_j*DW +: DW]);
      end
      checks++;
      if (in_latency !== lat_all(5'd3)) begin
         errors++; $display("FAIL single_in_latency: got %h expected %h", in_latency, lat_all(5'd3));
      end
      step();
      checks++;
      if (out_valid !== 4'h0) begin errors++; $display("FAIL single_drained: got %h expected 0", out_valid); end
   endtask

   task automatic test_multi_grant();
      logic [NO-1:0] exp_v;
      int            j0, j1;
`ifdef SWITCH_LATENCY_AWARE_EN
      exp_v = 4'b0110; j0 = 1; j1 = 2;
`else
      exp_v = 4'b0011; j0 = 0; j1 = 1;
`endif
      set_lat(5'd3, 5'd1, 5'd2, 5'd4);
      out_ready = '1;
      do_reset();
      in_valid = 4'b0011; in_data[15:0] = 16'h1111; in_data[31:16] = 16'h2222;
      step();
      in_valid = '0;
      step();
      checks++;
      if (out_valid !== exp_v) begin errors++; $display("FAIL multi_out_valid: got %b expected %b", out_valid, exp_v); end
      checks++;
      if (out_data[j0*DW +: DW] !== 16'h1111 || out_data[j1*DW +: DW] !== 16'h2222) begin
         errors++;
         $display("FAIL multi_out_data: got %h/%h expected 1111/2222", out_data[j0*DW +: DW], out_data[j1*DW +: DW]);
      end
   endtask

   task automatic test_backpressure();
      int   accepted = 0;
      int   total = 0;
      int   seen [1:6];
      logic acc;
      logic [DW-1:0] v;
      set_lat(5'd3, 5'd1, 5'd2, 5'd4);
      out_ready = '0;
      do_reset();
      for (int k = 1; k <= 6; k++) seen[k] = 0;
      for (int c = 0; c < 12; c++) begin
         in_valid = 4'b0100;
         in_data[2*DW +: DW] = DW'(accepted + 1);
         acc = in_ready[2];
         step();
         if (acc) accepted++;
      end
      checks++;
      if (accepted != 6) begin errors++; $display("FAIL bp_accept_count: got %0d expected 6", accepted); end
      checks++;
      if (in_ready[2] !== 1'b0) begin errors++; $display("FAIL bp_ready_low: got %b expected 0", in_ready[2]); end
      in_valid  = '0;
      out_ready = '1;
      for (int c = 0; c < 12; c++) begin
         for (int j = 0; j < NO; j++) begin
            if (out_valid[j]) begin
               v = out_data[j*DW +: DW];
               total++;
               if (v >= 1 && v <= 6) seen[int'(v)]++;
            end
         end
         step();
      end
      checks++;
      if (total != 6) begin errors++; $display("FAIL bp_total_delivered: got %0d expected 6", total); end
      for (int k = 1; k <= 6; k++) begin
         checks++;
         if (seen[k] != 1) begin errors++; $display("FAIL bp_beat_%0d_once: got %0d copies expected 1", k, seen[k]); end
      end
   endtask

   task automatic test_fairness();
      int            seq [NI];
      logic [NI-1:0] acc;
      logic [DW-1:0] beats [17];
      logic [DW-1:0] exp;
      int            nb = 0;
      set_lat(5'd5, 5'd5, 5'd5, 5'd5);
      out_ready = 4'b0001;
      do_reset();
      for (int i = 0; i < NI; i++) seq[i] = 0;
      for (int c = 0; c < 300 && nb < 17; c++) begin
         in_valid = '1;
         for (int i = 0; i < NI; i++) in_data[i*DW +: DW] = {4'(i), 12'(seq[i])};
         acc = in_ready;
         if (out_valid[0]) begin beats[nb] = out_data[DW-1:0]; nb++; end
         step();
         for (int i = 0; i < NI; i++) if (acc[i]) seq[i]++;
      end
      in_valid = '0;
      checks++;
      if (nb != 17) begin
         errors++; $display("FAIL fair_timeout: got %0d beats expected 17", nb);
      end else begin
         for (int k = 0; k < 17; k++) begin
            exp = (k == 0) ? 16'h0000 : {4'((k - 1) % 4), 12'(1 + (k - 1) / 4)};
            checks++;
            if (beats[k] !== exp) begin errors++; $display("FAIL fair_beat_%0d: got %h expected %h", k, beats[k], exp); end
         end
      end
   endtask

   task automatic test_ties_saturation();
      logic [LW-1:0] tbl_l [5] = '{5'd31, 5'd30, 5'd29, 5'd28, 5'd31};
      logic [LW-1:0] tbl_l3 [5] = '{5'd31, 5'd30, 5'd29, 5'd28, 5'd0};
      logic [LW-1:0] tbl_e [5] = '{5'd31, 5'd31, 5'd31, 5'd30, 5'd2};
      set_lat(5'd5, 5'd5, 5'd5, 5'd5);
      out_ready = '1;
      do_reset();
      in_valid = 4'b0010; in_data[31:16] = 16'hABCD;
      step();
      in_valid = '0;
      step();
      checks++;
      if (out_valid !== 4'b0001) begin errors++; $display("FAIL tie_out_valid: got %b expected 0001", out_valid); end
      checks++;
      if (out_data[15:0] !== 16'hABCD) begin errors++; $display("FAIL tie_out_data: got %h expected abcd", out_data[15:0]); end
      checks++;
      if (in_latency !== lat_all(5'd7)) begin
         errors++; $display("FAIL tie_in_latency: got %h expected %h", in_latency, lat_all(5'd7));
      end
      for (int t = 0; t < 5; t++) begin
         set_lat(tbl_l[t], tbl_l[t], tbl_l[t], tbl_l3[t]);
         step();
         checks++;
         if (in_latency !== lat_all(tbl_e[t])) begin
            errors++; $display("FAIL sat_case_%0d: got %h expected %h", t, in_latency, lat_all(tbl_e[t]));
         end
      end
   endtask

   task automatic test_reset_mid();
      int vcount = 0;
      set_lat(5'd3, 5'd1, 5'd2, 5'd4);
      out_ready = '0;
      do_reset();
      for (int k = 0; k < 3; k++) begin
         in_valid = 4'b1000;
         in_data[3*DW +: DW] = 16'h3001 + 16'(k);
         step();
      end
      in_valid = '0;
      step();
      rst = 1'b1;
      #1;
      checks++;
      if (in_ready !== 4'h0) begin errors++; $display("FAIL mid_ready_in_reset: got %h expected 0", in_ready); end
      step();
      checks++;
      if (out_valid !== 4'h0) begin errors++; $display("FAIL mid_out_valid: got %h expected 0", out_valid); end
      checks++;
      if (out_data !== '0) begin errors++; $display("FAIL mid_out_data: got %h expected 0", out_data); end
      checks++;
      if (in_latency !== lat_all(5'd31)) begin
         errors++; $display("FAIL mid_in_latency: got %h expected %h", in_latency, lat_all(5'd31));
      end
      rst = 1'b0;
      #1;
      checks++;
      if (in_ready !== 4'hF) begin errors++; $display("FAIL mid_ready_after: got %h expected f", in_ready); end
      out_ready = '1;
      for (int c = 0; c < 10; c++) begin
         if (out_valid !== 4'h0) vcount++;
         step();
      end
      checks++;
      if (vcount != 0) begin errors++; $display("FAIL mid_old_beat_seen: got %0d valid cycles expected 0", vcount); end
   endtask

   initial begin
      test_reset();
      test_single_beat();
      test_multi_grant();
      test_backpressure();
      test_fairness();
      test_ties_saturation();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/latency_aware_switch.md
# latency_aware_switch

Registered N-input × M-output crossbar switch for the engine interconnect. Successor to the combinational 2×2 switch:
- Parametrised port counts.
- Per-input buffering.
- Round-robin input fairness.
- Registered outputs.
- Latency-aware output selection with saturating upstream latency reporting.

It sits between engine clusters and core groups, so deeper trees can be built without long combinational valid/ready paths.

## Interface
- `DWIDTH`, 16: payload width.
- `LATENCY_COUNT_WIDTH`, 5: latency metric width.
- `N_IN`, 4: input ports, ≥2.
- `N_OUT`, 4: output ports, ≥2.
- `IN_DEPTH`, 2: per-input FIFO entries, power of two, ≥2.

- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `in_valid` in N_IN: per-input valid.
- `in_data` in N_IN*DWIDTH: input i at [i*DWIDTH +: DWIDTH].
- `in_ready` out N_IN: per-input ready.
- `in_latency` out N_IN*LATENCY_COUNT_WIDTH: latency reported upstream, per input.
- `out_valid` out N_OUT: per-output valid.
- `out_data` out N_OUT*DWIDTH: output payload.
- `out_ready` in N_OUT: downstream ready.
- `out_latency` in N_OUT*LATENCY_COUNT_WIDTH: latency advertised by downstream j.

## Operation
- **Input FIFOs.** Input i owns an IN_DEPTH FIFO.
  - `in_ready[i]` = FIFO not full. It is registered-state derived and has no combinational path from `out_ready`.
  - A beat is accepted when `in_valid & in_ready`.
  - Enqueue and dequeue in the same cycle are allowed; the count is then unchanged.
- **Output registers.** Output j is a one-entry register.
  - It is *available* in a cycle if it is empty, or if `out_valid[j] & out_ready[j]`, i.e. draining this cycle.
- **Allocation, each cycle.**
  - Nonempty inputs are visited in round-robin order starting at pointer `rr`.
  - Each visited input is matched to the best still-unassigned available output.
  - "Best" means the lowest `out_latency`; ties go to the lowest index.
  - Grants per cycle = min(nonempty inputs, available outputs).
  - A granted input dequeues its head into the chosen output register at the clock edge.
- **Round-robin pointer.** `rr` advances to (last granted input + 1) mod N_IN whenever at least one grant occurs; otherwise it holds.
- **Data integrity.** No beat is ever dropped or duplicated, and per-input order is preserved.
- **Latency report.** `in_latency` (all inputs, same value) = min over j of `out_latency[j]` + 2.
  - The +2 is the switch's own latency.
  - The result saturates at 2^LATENCY_COUNT_WIDTH−1.
  - Computed at LATENCY_COUNT_WIDTH+1 bits, then clamped.
  - Registered: it reflects `out_latency` from the previous cycle.
- **Reset** (`rst` high at an edge): all FIFOs emptied and buffered beats discarded, `rr`=0, `out_valid`=0, `out_data`=0, `in_latency`=all ones.
  - `in_ready` is 0 during the reset cycle and 1 in the first cycle after `rst` falls.
  - Reset mid-transfer discards all state without emitting partial results.

## Timing
- Beat accepted at edge E → earliest `out_valid` is after edge E+1, i.e. 2 cycles of latency.
- Sustained throughput: 1 beat/cycle per input, min(N_IN, N_OUT) beats/cycle in aggregate.
- An output register holds data and valid stable until `out_ready`; valid never drops without a handshake.
- Edge cases:
  - FIFO full and dequeued in the same cycle: `in_ready` stays 0 that cycle and rises the next.
  - Output draining and reloaded in the same cycle: back-to-back valid, no bubble.

## Configuration
- `SWITCH_LATENCY_AWARE_EN` defined:
  - Output selection by lowest `out_latency` as above.
  - `in_latency` computed as above.
- Undefined:
  - Selection is lowest-index available output.
  - `out_latency` is ignored.
  - `in_latency` is driven constant 0, including in reset.
  - No latency comparator or adder logic is generated.

## Test plan
All with default parameters, macro defined unless stated.

- **Single beat:** `out_latency`={3,1,2,4}, all `out_ready`=1; input 0 sends 0x00FF → `out_valid`={0,1,0,0} with `out_data[1]`=0x00FF two cycles later; `in_latency`=3 on all inputs.
- **Backpressure fill:** all `out_ready`=0; input 2 held valid with data 1,2,3,…
  - Exactly 6 beats accepted (4 output registers + 2 FIFO), then `in_ready[2]`=0.
  - After raising `out_ready`, beats 1–6 are delivered, each exactly once.
- **Fairness:** all inputs continuously valid with tagged data; only `out_ready[0]`=1, all latencies equal.
  - After the initial fill, 16 consecutive out_0 beats contain each input's tag exactly 4 times, in order 0,1,2,3 repeating.
- **Ties and saturation:**
  - All `out_latency`=5 → first beat lands on out_0; `in_latency`=7.
  - All `out_latency`=31 → `in_latency`=31 (saturated, no wrap).
- **Reset mid-operation:** with 3 beats buffered, assert `rst` one cycle.
  - Next cycle: `out_valid`=0, `in_latency`=31; after `rst` deassertion `in_ready`=all 1 and no old beat ever appears.
- **Macro undefined:** `out_latency`={3,1,2,4}, single beat → delivered on out_0; `in_latency`=0.
